// File: rtl/operand_collector.sv
// operand_collector: packs a stream of W-bit operands into eight adder-tree slots,
// waits for the tree to settle, then captures its result with overflow and mismatch flags.
//
// state      | meaning
// COLLECT    | accepting operands into slots m..t
// SETTLE     | slots frozen, counting down while the tree settles
// HOLD       | result presented, waiting for out_ready
module operand_collector #(
  parameter int W      = 7,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic [W-1:0] m,
  output logic [W-1:0] n,
  output logic [W-1:0] o,
  output logic [W-1:0] p,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic [W-1:0] s,
  output logic [W-1:0] t,
  input  logic [W+1:0] sum_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+2:0] out_sum,
  output logic [W+1:0] out_tree,
  output logic [3:0]   out_count,
  output logic         out_ovf,
  output logic         out_mis
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t       state;
  logic [3:0]   idx;
  logic [3:0]   cnt;
  logic [W+2:0] acc;
  logic [W-1:0] slot [8];

  assign in_ready = (state == ST_COLLECT);

  assign m = slot[0];
  assign n = slot[1];
  assign o = slot[2];
  assign p = slot[3];
  assign q = slot[4];
  assign r = slot[5];
  assign s = slot[6];
  assign t = slot[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_COLLECT;
      idx       <= '0;
      cnt       <= '0;
      acc       <= '0;
      for (int i = 0; i < 8; i++) slot[i] <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tree  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_mis   <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (in_valid) begin
            slot[idx[2:0]] <= in_data;
            idx            <= idx + 4'd1;
            acc            <= acc + {3'b000, in_data};
            // in_last on the eighth operand is still a single group end
            if (idx == 4'd7 || in_last) begin
              cnt   <= SETTLE_CNT;
              state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt <= 4'd1) begin
            out_tree  <= sum_in;
            out_sum   <= acc;
            out_count <= idx;
            out_ovf   <= acc[W+2];
            out_mis   <= (acc[W+1:0] != sum_in);
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= '0;
            acc       <= '0;
            for (int i = 0; i < 8; i++) slot[i] <= '0;
            state     <= ST_COLLECT;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: an operand-list model predicts slots, handshakes and
// results every cycle, plus directed groups with hand-computed literal results.
module tb_operand_collector;
  localparam int W      = 7;
  localparam int SETTLE = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, out_ovf, out_mis;
  logic [W-1:0] m, n, o, p, q, r, s, t;
  logic [W+1:0] sum_in, out_tree;
  logic [W+2:0] out_sum;
  logic [3:0]   out_count;
  logic [W+1:0] force_err = '0;
  logic [W-1:0] sl [8];

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int ops[$];
  bit m_busy = 0, m_valid = 0;
  int m_age = 0, msum = 0;
  int e_sum = 0, e_tree = 0, e_count = 0;
  bit e_ovf = 0, e_mis = 0;

  operand_collector #(.W(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .m(m), .n(n), .o(o), .p(p), .q(q), .r(r), .s(s), .t(t),
    .sum_in(sum_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_tree(out_tree), .out_count(out_count),
    .out_ovf(out_ovf), .out_mis(out_mis)
  );

  always #5 clk = ~clk;

  // stand-in for the adder tree, W+2 bits wide so it wraps like the real one
  assign sum_in = (W+2)'(m) + (W+2)'(n) + (W+2)'(o) + (W+2)'(p)
                + (W+2)'(q) + (W+2)'(r) + (W+2)'(s) + (W+2)'(t) + force_err;

  assign sl[0] = m; assign sl[1] = n; assign sl[2] = o; assign sl[3] = p;
  assign sl[4] = q; assign sl[5] = r; assign sl[6] = s; assign sl[7] = t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a group is the list of accepted operands; the result appears SETTLE
  // edges after the group-ending accept and stays until out_ready is seen.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ops.delete();
      m_busy = 0; m_valid = 0; m_age = 0;
      e_sum = 0; e_tree = 0; e_count = 0; e_ovf = 0; e_mis = 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 0;
        m_busy  = 0;
        ops.delete();
      end
    end else if (m_busy) begin
      m_age++;
      if (m_age >= SETTLE) begin
        msum = 0;
        foreach (ops[i]) msum += ops[i];
        e_sum   = msum;
        e_tree  = (msum + int'(force_err)) % 512;
        e_count = ops.size();
        e_ovf   = (msum >= 512);
        e_mis   = (force_err != 0);
        m_valid = 1;
      end
    end else if (in_valid) begin
      ops.push_back(int'(in_data));
      if (ops.size() == 8 || in_last) begin
        m_busy = 1;
        m_age  = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(!m_busy));
    chk("out_valid", int'(out_valid), int'(m_valid));
    for (int i = 0; i < 8; i++)
      chk($sformatf("slot%0d", i), int'(sl[i]), (i < ops.size()) ? ops[i] : 0);
    chk("out_sum", int'(out_sum), e_sum);
    chk("out_tree", int'(out_tree), e_tree);
    chk("out_count", int'(out_count), e_count);
    chk("out_ovf", int'(out_ovf), int'(e_ovf));
    chk("out_mis", int'(out_mis), int'(e_mis));
  end

  task automatic send(input int v, input bit last);
    int g = 0;
    in_valid = 1'b1;
    in_data  = W'(v);
    in_last  = last;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // returns edges from the group-ending accept (inclusive) to out_valid
  task automatic wait_valid(output int lat);
    int k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
    lat = k + 1;
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_sum", int'(out_sum), 0);

    // 1..8 back to back, consumer always ready
    for (int i = 1; i <= 8; i++) send(i, 1'b0);
    wait_valid(lat);
    chk("t1_latency", lat, 2);
    chk("t1_sum", int'(out_sum), 36);
    chk("t1_tree", int'(out_tree), 36);
    chk("t1_count", int'(out_count), 8);
    chk("t1_m", int'(m), 1);
    chk("t1_t", int'(t), 8);
    @(posedge clk); #1;
    chk("t1_back_collect", int'(in_ready), 1);

    // short group 5,6,7 then a long HOLD with in_valid noise
    out_ready = 1'b0;
    send(5, 1'b0); send(6, 1'b0); send(7, 1'b1);
    wait_valid(lat);
    chk("t2_sum", int'(out_sum), 18);
    chk("t2_count", int'(out_count), 3);
    chk("t2_p", int'(p), 0);
    chk("t2_t", int'(t), 0);
    in_valid = 1'b1; in_data = 7'd100; in_last = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_hold_sum", int'(out_sum), 18);
    chk("t4_hold_m", int'(m), 5);
    chk("t4_hold_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4_done_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("t4_no_bypass_m", int'(m), 0);

    // full-scale operands: tree wraps
    for (int i = 0; i < 8; i++) send(127, 1'b0);
    wait_valid(lat);
    chk("t3_sum", int'(out_sum), 1016);
    chk("t3_tree", int'(out_tree), 504);
    chk("t3_ovf", int'(out_ovf), 1);
    chk("t3_mis", int'(out_mis), 0);
    @(posedge clk); #1;

    // reset in the middle of a group
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_m", int'(m), 0);
    chk("t5_rst_sum", int'(out_sum), 0);
    chk("t5_rst_ovf", int'(out_ovf), 0);
    chk("t5_rst_ready", int'(in_ready), 1);
    @(posedge clk); #1 rst = 1'b0;
    send(2, 1'b0); send(3, 1'b1);
    wait_valid(lat);
    chk("t5_sum", int'(out_sum), 5);
    chk("t5_count", int'(out_count), 2);
    @(posedge clk); #1;

    // tree result off by one
    force_err = 9'd1;
    send(10, 1'b0); send(20, 1'b1);
    wait_valid(lat);
    chk("t6_mis", int'(out_mis), 1);
    chk("t6_tree", int'(out_tree), 31);
    chk("t6_sum", int'(out_sum), 30);
    @(posedge clk); #1;
    force_err = '0;

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
